// File: rtl/zilla_lsu.sv
// zilla_lsu: load/store unit between execute and the writeback mux.
// Issues one data-memory transaction at a time over a req/gnt/rvalid bus,
// stalls the pipeline while it is outstanding, and returns aligned,
// extended load data. Misaligned or illegal-size requests are rejected
// with a one-cycle pulse and never reach the bus.
module zilla_lsu #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // execute-stage request
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [1:0]              mem_size_i,
  input  logic                    mem_unsigned_i,
  input  logic [DATA_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [4:0]              rd_i,
  // pipeline / writeback side
  output logic                    lsu_stall_o,
  output logic                    load_valid_o,
  output logic [DATA_WIDTH-1:0]   load_data_o,
  output logic [4:0]              load_rd_o,
  output logic                    misaligned_o,
  // data-memory bus
  output logic                    dmem_req_o,
  output logic                    dmem_we_o,
  output logic [DATA_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH/8-1:0] dmem_be_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  input  logic                    dmem_gnt_i,
  input  logic                    dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e                state_q, state_d;
  logic                  bus_we_q, bus_we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            off_q, off_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [NumBytes-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  load_valid_q, load_valid_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic [4:0]            load_rd_q, load_rd_d;
  logic                  misaligned_q, misaligned_d;

  logic                  misaligned;
  logic                  accept;
  logic [NumBytes-1:0]   req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] rdata_shifted;
  logic [DATA_WIDTH-1:0] rdata_ext;

  // Alignment check and bus-field formatting for the incoming request
  always_comb begin
    misaligned = ((mem_size_i == SizeHalf) && addr_i[0])            ||
                 ((mem_size_i == SizeWord) && (addr_i[1:0] != 2'b00)) ||
                 (mem_size_i == 2'b11);
    accept     = (state_q == StIdle) && mem_req_i;

    req_be    = {NumBytes{1'b1}};
    req_wdata = wdata_i;
    unique case (mem_size_i)
      SizeByte: begin
        req_be    = NumBytes'(1) << addr_i[1:0];
        req_wdata = {NumBytes{wdata_i[7:0]}};
      end
      SizeHalf: begin
        req_be    = NumBytes'(3) << {addr_i[1], 1'b0};
        req_wdata = {(NumBytes / 2){wdata_i[15:0]}};
      end
      default: begin
        req_be    = {NumBytes{1'b1}};
        req_wdata = wdata_i;
      end
    endcase
  end

  // Lane-select and extend the returned read data
  always_comb begin
    rdata_shifted = dmem_rdata_i >> {off_q, 3'b000};
    rdata_ext     = rdata_shifted;
    unique case (size_q)
      SizeByte: rdata_ext = uns_q ? DATA_WIDTH'(rdata_shifted[7:0]) :
                            {{(DATA_WIDTH - 8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      SizeHalf: rdata_ext = uns_q ? DATA_WIDTH'(rdata_shifted[15:0]) :
                            {{(DATA_WIDTH - 16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      default:  rdata_ext = rdata_shifted;
    endcase
  end

  // FSM next state and captured transaction fields
  always_comb begin
    state_d      = state_q;
    bus_we_d     = bus_we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    load_rd_d    = load_rd_q;
    misaligned_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            state_d  = StReq;
            bus_we_d = mem_we_i;
            size_d   = mem_size_i;
            uns_d    = mem_unsigned_i;
            off_d    = addr_i[1:0];
            rd_d     = rd_i;
            addr_d   = {addr_i[DATA_WIDTH-1:2], 2'b00};
            be_d     = req_be;
            wdata_d  = req_wdata;
          end
        end
      end
      StReq: begin
        if (dmem_gnt_i) begin
          state_d = bus_we_q ? StIdle : StWait;
        end
      end
      StWait: begin
        if (dmem_rvalid_i) begin
          state_d      = StIdle;
          load_valid_d = 1'b1;
          load_data_d  = rdata_ext;
          load_rd_d    = rd_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      bus_we_q     <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= 5'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_we_q     <= bus_we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      load_rd_q    <= load_rd_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Output drive; write strobe only meaningful while requesting
  always_comb begin
    lsu_stall_o  = (state_q != StIdle) || (accept && !misaligned);
    load_valid_o = load_valid_q;
    load_data_o  = load_data_q;
    load_rd_o    = load_rd_q;
    misaligned_o = misaligned_q;
    dmem_req_o   = (state_q == StReq);
    dmem_we_o    = bus_we_q && (state_q == StReq);
    dmem_addr_o  = addr_q;
    dmem_be_o    = be_q;
    dmem_wdata_o = wdata_q;
  end

endmodule

// File: tb/tb_zilla_lsu.sv
// Self-checking bench for zilla_lsu: a directed driver plays execute stage
// and memory; expected bus fields and load results go into scoreboard
// queues and are checked by a negedge monitor when the DUT produces them.
module tb_zilla_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        lsu_stall_o;
  logic        load_valid_o;
  logic [31:0] load_data_o;
  logic [4:0]  load_rd_o;
  logic        misaligned_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  always #5 clk_i = ~clk_i;

  zilla_lsu #(.DATA_WIDTH(32)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .rd_i           (rd_i),
    .lsu_stall_o    (lsu_stall_o),
    .load_valid_o   (load_valid_o),
    .load_data_o    (load_data_o),
    .load_rd_o      (load_rd_o),
    .misaligned_o   (misaligned_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  bus_t bus_q[$];
  ld_t  ld_q[$];
  bus_t mon_bus;
  ld_t  mon_ld;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus fields must match the scoreboard head every cycle the request is up
  always @(negedge clk_i) begin
    if (dmem_req_o) begin
      if (bus_q.size() == 0) begin
        check_eq("unexpected_req", dmem_req_o, 1'b0);
      end else begin
        mon_bus = bus_q[0];
        check_eq("bus_we", dmem_we_o, mon_bus.we);
        check_eq("bus_addr", dmem_addr_o, mon_bus.addr);
        check_eq("bus_be", dmem_be_o, mon_bus.be);
        if (mon_bus.we) check_eq("bus_wdata", dmem_wdata_o, mon_bus.wdata);
        if (dmem_gnt_i) mon_bus = bus_q.pop_front();
      end
    end
    if (load_valid_o) begin
      if (ld_q.size() == 0) begin
        check_eq("unexpected_load_valid", load_valid_o, 1'b0);
      end else begin
        mon_ld = ld_q.pop_front();
        check_eq("load_data", load_data_o, mon_ld.data);
        check_eq("load_rd", load_rd_o, mon_ld.rd);
      end
    end
  end

  task automatic run_txn(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] rdata, input int gnt_dly,
                         input int rv_dly, input logic bad, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] edata);
    bus_t b;
    ld_t  l;
    @(posedge clk_i); #1;
    mem_req_i      = 1'b1;
    mem_we_i       = we;
    mem_size_i     = size;
    mem_unsigned_i = uns;
    addr_i         = addr;
    wdata_i        = wdata;
    rd_i           = rd;
    if (!bad) begin
      b.we = we; b.addr = {addr[31:2], 2'b00}; b.be = ebe; b.wdata = ewd;
      bus_q.push_back(b);
      if (!we) begin
        l.rd = rd; l.data = edata;
        ld_q.push_back(l);
      end
    end
    #1 check_eq({tag, "_stall_t0"}, lsu_stall_o, !bad);
    @(posedge clk_i); #1;
    mem_req_i = 1'b0;
    if (bad) begin
      check_eq({tag, "_mis_t1"}, misaligned_o, 1'b1);
      check_eq({tag, "_stall_t1"}, lsu_stall_o, 1'b0);
      check_eq({tag, "_req_t1"}, dmem_req_o, 1'b0);
      @(posedge clk_i); #1;
      check_eq({tag, "_mis_t2"}, misaligned_o, 1'b0);
      check_eq({tag, "_req_t2"}, dmem_req_o, 1'b0);
      return;
    end
    check_eq({tag, "_req_t1"}, dmem_req_o, 1'b1);
    check_eq({tag, "_stall_t1"}, lsu_stall_o, 1'b1);
    for (int i = 0; i < gnt_dly; i++) begin
      @(posedge clk_i); #1;
      check_eq({tag, "_req_held"}, dmem_req_o, 1'b1);
      check_eq({tag, "_stall_req"}, lsu_stall_o, 1'b1);
    end
    dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    check_eq({tag, "_req_after_gnt"}, dmem_req_o, 1'b0);
    if (we) begin
      check_eq({tag, "_stall_done"}, lsu_stall_o, 1'b0);
      return;
    end
    check_eq({tag, "_stall_wait"}, lsu_stall_o, 1'b1);
    for (int i = 0; i < rv_dly; i++) begin
      @(posedge clk_i); #1;
      check_eq({tag, "_stall_wait"}, lsu_stall_o, 1'b1);
      check_eq({tag, "_lv_early"}, load_valid_o, 1'b0);
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    check_eq({tag, "_lv"}, load_valid_o, 1'b1);
    check_eq({tag, "_stall_t3"}, lsu_stall_o, 1'b0);
    check_eq({tag, "_data"}, load_data_o, edata);
    check_eq({tag, "_rd"}, load_rd_o, rd);
    @(posedge clk_i); #1;
    check_eq({tag, "_lv_pulse"}, load_valid_o, 1'b0);
    check_eq({tag, "_data_hold"}, load_data_o, edata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00;
    mem_unsigned_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; rd_i = 5'd0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_req", dmem_req_o, 1'b0);
    check_eq("rst_stall", lsu_stall_o, 1'b0);
    check_eq("rst_lv", load_valid_o, 1'b0);
    check_eq("rst_mis", misaligned_o, 1'b0);
    check_eq("rst_data", load_data_o, 32'h0);
    check_eq("rst_rd", load_rd_o, 5'd0);
    check_eq("rst_addr", dmem_addr_o, 32'h0);
    check_eq("rst_be", dmem_be_o, 4'h0);
    check_eq("rst_we", dmem_we_o, 1'b0);
    rst_i = 1'b0;

    //       tag      we    size   uns   addr          wdata         rd     rdata         g  r  bad   be       wd            data
    run_txn("lw",     1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        5'd5,  32'hDEAD_BEEF, 0, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    run_txn("lb",     1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        5'd7,  32'h80FF_FF7F, 0, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80);
    run_txn("lbu",    1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        5'd8,  32'h80FF_FF7F, 0, 0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080);
    run_txn("lh",     1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        5'd9,  32'h80FF_FF7F, 0, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF_80FF);
    run_txn("lhu",    1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,        5'd10, 32'h80FF_FF7F, 0, 0, 1'b0, 4'b0011, 32'h0,        32'h0000_FF7F);
    run_txn("sh",     1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'h1234_ABCD, 5'd0, 32'h0,         0, 0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    run_txn("sb",     1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00A5, 5'd0, 32'h0,         0, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    run_txn("sw_dly", 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0BAD_F00D, 5'd0, 32'h0,         2, 0, 1'b0, 4'b1111, 32'h0BAD_F00D, 32'h0);
    check_eq("data_hold_after_stores", load_data_o, 32'h0000_FF7F);
    run_txn("mis_w",  1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        5'd1,  32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        32'h0);
    run_txn("mis_sz", 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        5'd1,  32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        32'h0);
    run_txn("mis_h",  1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h0,        5'd1,  32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        32'h0);
    run_txn("lw_dly", 1'b0, 2'b10, 1'b0, 32'h0000_040C, 32'h0,        5'd31, 32'h1234_5678, 3, 2, 1'b0, 4'b1111, 32'h0,        32'h1234_5678);

    // Reset while waiting for read data; the late rvalid must be dropped
    begin
      bus_t b;
      @(posedge clk_i); #1;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10; mem_unsigned_i = 1'b0;
      addr_i = 32'h0000_0500; rd_i = 5'd3;
      b.we = 1'b0; b.addr = 32'h0000_0500; b.be = 4'b1111; b.wdata = 32'h0;
      bus_q.push_back(b);
      @(posedge clk_i); #1;
      mem_req_i  = 1'b0;
      dmem_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      dmem_gnt_i = 1'b0;
      check_eq("rstw_stall_wait", lsu_stall_o, 1'b1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i         = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hCAFE_F00D;
      check_eq("rstw_stall", lsu_stall_o, 1'b0);
      check_eq("rstw_req", dmem_req_o, 1'b0);
      check_eq("rstw_data_cleared", load_data_o, 32'h0);
      @(posedge clk_i); #1;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'h0;
      check_eq("rstw_lv", load_valid_o, 1'b0);
      check_eq("rstw_stall2", lsu_stall_o, 1'b0);
      check_eq("rstw_data", load_data_o, 32'h0);
      @(posedge clk_i); #1;
      check_eq("rstw_lv2", load_valid_o, 1'b0);
    end

    check_eq("bus_queue_empty", bus_q.size(), 0);
    check_eq("load_queue_empty", ld_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
